// File: rtl/sprite_line_writer.sv
// Sprite line writer: renders one row of an intersecting sprite into the line
// buffer. For each visible tile it fetches one 8-pixel tile row, then writes up
// to eight pixels, skipping transparent and off-screen pixels.
module sprite_line_writer #(
   parameter int LINE_WIDTH = 640
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [2:0]  sizeX,
   input  logic [2:0]  first,
   input  logic [2:0]  last,
   input  logic [3:0]  tileX,
   input  logic [3:0]  tile_y_total,
   input  logic [2:0]  tile_y_offset,
   input  logic        hFlip,
   output logic [10:0] tile_addr,
   input  logic [31:0] tile_data,
   output logic        lb_we,
   output logic [9:0]  lb_addr,
   output logic [3:0]  lb_data,
   output logic        busy,
   output logic        done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [15:0] LW = 16'(LINE_WIDTH);

   logic [2:0]  state_q, state_d;
   logic [2:0]  t_q, t_d;
   logic [2:0]  p_q, p_d;
   logic [15:0] a_q, a_d;
   logic [2:0]  sizex_q, sizex_d;
   logic [2:0]  last_q, last_d;
   logic [3:0]  tilex_q, tilex_d;
   logic [3:0]  tyt_q, tyt_d;
   logic [2:0]  tyo_q, tyo_d;
   logic        hflip_q, hflip_d;
   logic [31:0] pix_q, pix_d;
   logic [10:0] tile_addr_q, tile_addr_d;

   logic [3:0]  pix_sel;
   logic [15:0] x;
   logic        x_on_line;

   // Tile memory address for tile t; the column wraps within 16 tiles.
   function automatic logic [10:0] calc_addr(input logic [3:0] tx, input logic [3:0] ty,
                                             input logic [2:0] sx, input logic [2:0] to,
                                             input logic [2:0] t,  input logic hf);
      logic [3:0] off;
      logic [3:0] col;
      off = hf ? ({1'b0, sx} - {1'b0, t}) : {1'b0, t};
      col = tx + off;
      return {ty, col, to};
   endfunction

   // Next-state logic: fetch a tile row, wait one cycle for memory, write 8 pixels.
   always_comb begin
      state_d     = state_q;
      t_d         = t_q;
      p_d         = p_q;
      a_d         = a_q;
      sizex_d     = sizex_q;
      last_d      = last_q;
      tilex_d     = tilex_q;
      tyt_d       = tyt_q;
      tyo_d       = tyo_q;
      hflip_d     = hflip_q;
      pix_d       = pix_q;
      tile_addr_d = tile_addr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               sizex_d = sizeX;
               last_d  = last;
               tilex_d = tileX;
               tyt_d   = tile_y_total;
               tyo_d   = tile_y_offset;
               hflip_d = hFlip;
               if (first > last) begin
                  state_d = S_DONE;
               end else begin
                  t_d         = first;
                  tile_addr_d = calc_addr(tileX, tile_y_total, sizeX, tile_y_offset, first, hFlip);
                  state_d     = S_FETCH;
               end
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            pix_d   = tile_data;
            p_d     = 3'd0;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            // Shift so the next pixel in screen order is always at the output end.
            pix_d = hflip_q ? {pix_q[27:0], 4'h0} : {4'h0, pix_q[31:4]};
            p_d   = p_q + 3'd1;
            if (p_q == 3'd7) begin
               if (t_q == last_q) begin
                  state_d = S_DONE;
               end else begin
                  t_d         = t_q + 3'd1;
                  tile_addr_d = calc_addr(tilex_q, tyt_q, sizex_q, tyo_q, t_q + 3'd1, hflip_q);
                  state_d     = S_FETCH;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         t_q         <= 3'd0;
         p_q         <= 3'd0;
         a_q         <= 16'd0;
         sizex_q     <= 3'd0;
         last_q      <= 3'd0;
         tilex_q     <= 4'd0;
         tyt_q       <= 4'd0;
         tyo_q       <= 3'd0;
         hflip_q     <= 1'b0;
         pix_q       <= 32'd0;
         tile_addr_q <= 11'd0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         p_q         <= p_d;
         a_q         <= a_d;
         sizex_q     <= sizex_d;
         last_q      <= last_d;
         tilex_q     <= tilex_d;
         tyt_q       <= tyt_d;
         tyo_q       <= tyo_d;
         hflip_q     <= hflip_d;
         pix_q       <= pix_d;
         tile_addr_q <= tile_addr_d;
      end
   end

   // Pixel output: screen x = a + 8*t + p, where 8*t + p is just {t, p}.
   always_comb begin
      pix_sel   = hflip_q ? pix_q[31:28] : pix_q[3:0];
      x         = a_q + {10'd0, t_q, p_q};
      x_on_line = !x[15] && (x < LW);
      lb_we     = (state_q == S_WRITE) && (pix_sel != 4'h0) && x_on_line;
      lb_addr   = x[9:0];
      lb_data   = pix_sel;
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      tile_addr = tile_addr_q;
   end

endmodule

// File: tb/tb_sprite_line_writer.sv
// Self-checking bench for sprite_line_writer: a behavioural tile memory with
// one cycle of read latency, and a scoreboard of expected line buffer writes.
module tb_sprite_line_writer;

   logic        clk = 1'b0;
   logic        reset_n, start, hFlip;
   logic [15:0] a;
   logic [2:0]  sizeX, first, last, tile_y_offset;
   logic [3:0]  tileX, tile_y_total;
   logic [10:0] tile_addr;
   logic [31:0] tile_data;
   logic        lb_we, busy, done;
   logic [9:0]  lb_addr;
   logic [3:0]  lb_data;

   logic [31:0] mem [0:2047];
   logic [13:0] exp_q [$];
   int          pass_cnt = 0;
   int          chk_cnt  = 0;
   int          done_cnt = 0;

   sprite_line_writer #(.LINE_WIDTH(640)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .a(a), .sizeX(sizeX),
      .first(first), .last(last), .tileX(tileX), .tile_y_total(tile_y_total),
      .tile_y_offset(tile_y_offset), .hFlip(hFlip), .tile_addr(tile_addr),
      .tile_data(tile_data), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Tile memory: data for the presented address appears one cycle later.
   always @(posedge clk) tile_data <= mem[tile_addr];

   // Scoreboard: every line buffer write must match the oldest expected one.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (lb_we) begin
         chk_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: got addr=%0d data=%0h, expected none", lb_addr, lb_data);
         end else begin
            logic [13:0] w;
            w = exp_q.pop_front();
            if (lb_addr !== w[13:4] || lb_data !== w[3:0])
               $display("FAIL write: got (%0d,%0h) expected (%0d,%0h)", lb_addr, lb_data, w[13:4], w[3:0]);
            else
               pass_cnt++;
         end
      end
   end

   // Run one request; stray = cycle to pulse start while busy, rstc = cycle to assert reset.
   task automatic run_case(input string nm, input logic [15:0] aa, input logic [2:0] sx,
                           input logic [2:0] fi, input logic [2:0] la, input logic [3:0] tx,
                           input logic [3:0] ty, input logic [2:0] to, input logic hf,
                           input logic [31:0] pat, input int exp_lat, input int stray, input int rstc);
      logic [10:0] addr0;
      int          lat, d0;
      addr0 = 11'd0;
      for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
      exp_q.delete();
      for (int t = int'(fi); t <= int'(la); t++) begin
         logic [3:0]  col;
         logic [10:0] ad;
         col = 4'(int'(tx) + (hf ? (int'(sx) - t) : t));
         ad  = {ty, col, to};
         if (t == int'(fi)) addr0 = ad;
         mem[ad] = pat;
         for (int p = 0; p < 8; p++) begin
            logic [3:0]  px;
            logic [15:0] x;
            px = 4'(pat >> (4 * (hf ? 7 - p : p)));
            x  = aa + 16'(8 * t + p);
            if (px != 4'h0 && !x[15] && x < 16'd640 && (rstc < 0 || 3 + 10 * (t - int'(fi)) + p <= rstc))
               exp_q.push_back({x[9:0], px});
         end
      end
      @(posedge clk); #1;
      a = aa; sizeX = sx; first = fi; last = la; tileX = tx;
      tile_y_total = ty; tile_y_offset = to; hFlip = hf; start = 1'b1;
      d0 = done_cnt;
      lat = -1;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c == 1 && fi <= la) begin
            chk_cnt++;
            if (tile_addr !== addr0) $display("FAIL %s tile_addr: got %h expected %h", nm, tile_addr, addr0);
            else pass_cnt++;
         end
         if (c == stray) begin
            start = 1'b1; a = 16'd0; first = 3'd0; last = 3'd7; hFlip = ~hf; tileX = tx + 4'd1;
         end
         if (rstc >= 0 && c == rstc + 1) begin
            chk_cnt++;
            if (busy !== 1'b0 || lb_we !== 1'b0 || done !== 1'b0 || tile_addr !== 11'd0 ||
                lb_addr !== 10'd0 || lb_data !== 4'd0)
               $display("FAIL %s abort_state: got busy=%b we=%b done=%b ta=%h la=%h ld=%h expected all 0",
                        nm, busy, lb_we, done, tile_addr, lb_addr, lb_data);
            else pass_cnt++;
            reset_n = 1'b1;
            break;
         end
         if (rstc >= 0 && c == rstc) reset_n = 1'b0;
         if (rstc < 0 && done === 1'b1) begin lat = c; break; end
      end
      if (rstc < 0) begin
         chk_cnt++;
         if (lat != exp_lat) $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
         else pass_cnt++;
      end
      repeat (15) @(posedge clk);
      #1;
      chk_cnt++;
      if (done_cnt - d0 != (rstc < 0 ? 1 : 0))
         $display("FAIL %s done_count: got %0d expected %0d", nm, done_cnt - d0, (rstc < 0 ? 1 : 0));
      else pass_cnt++;
      chk_cnt++;
      if (exp_q.size() != 0 || busy !== 1'b0)
         $display("FAIL %s leftover: got %0d missing writes busy=%b expected 0 and 0", nm, exp_q.size(), busy);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b1; a = 16'd5; sizeX = 3'd0; first = 3'd0; last = 3'd0;
      tileX = 4'd1; tile_y_total = 4'd1; tile_y_offset = 3'd1; hFlip = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++;
      if (busy !== 1'b0 || done !== 1'b0 || lb_we !== 1'b0 || tile_addr !== 11'd0 ||
          lb_addr !== 10'd0 || lb_data !== 4'd0)
         $display("FAIL reset_state: got busy=%b done=%b we=%b ta=%h la=%h ld=%h expected all 0",
                  busy, done, lb_we, tile_addr, lb_addr, lb_data);
      else pass_cnt++;
      start = 1'b0; reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_start_ignored: got busy=%b expected 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      run_case("basic", 16'd100, 3'd0, 3'd0, 3'd0, 4'd3, 4'd2, 3'd5, 1'b0, 32'h87654321, 11, -1, -1);
   endtask
   task automatic test_hflip();
      run_case("hflip", 16'd100, 3'd0, 3'd0, 3'd0, 4'd3, 4'd2, 3'd5, 1'b1, 32'h87654321, 11, -1, -1);
   endtask
   task automatic test_left_clip();
      run_case("left_clip", 16'hFFF4, 3'd2, 3'd1, 3'd2, 4'd14, 4'd7, 3'd2, 1'b0, 32'hFFFFFFFF, 21, -1, -1);
   endtask
   task automatic test_right_clip();
      run_case("right_clip", 16'd630, 3'd1, 3'd0, 3'd1, 4'd5, 4'd9, 3'd6, 1'b1, 32'hFFFFFFFF, 21, -1, -1);
   endtask
   task automatic test_transparent_busy();
      run_case("transp_busy", 16'd200, 3'd0, 3'd0, 3'd0, 4'd8, 4'd4, 3'd3, 1'b0, 32'h0F0F0F0F, 11, 5, -1);
   endtask
   task automatic test_abort();
      run_case("abort", 16'd100, 3'd0, 3'd0, 3'd0, 4'd3, 4'd2, 3'd5, 1'b0, 32'h87654321, 0, -1, 6);
   endtask
   task automatic test_empty();
      run_case("empty", 16'd50, 3'd3, 3'd3, 3'd1, 4'd2, 4'd2, 3'd2, 1'b0, 32'hFFFFFFFF, 1, -1, -1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hflip();
      test_left_clip();
      test_right_clip();
      test_transparent_busy();
      test_abort();
      test_empty();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
